// File: rtl/systolic_mac_pe.sv
// systolic_mac_pe: nibble-serial systolic processing element.
// Each frame of BEATS cycles carries one WORD_W word on the column line {A0,A1}
// and one on the row line {B0,B1}, MSB nibble first. A separate control bit per
// line carries the control word for that frame. Words and control words are
// forwarded to the neighbour PEs one frame later. A swap returns an accumulator
// to the neighbour and loads the incoming word in its place.
// The PE holds a 2x2 accumulator tile C00/C01/C10/C11. A MAC triggered in frame f
// performs its four products one per beat during frame f+1.
//
// MAC sequencer states:
//   state    | meaning
//   MAC_IDLE | no product pending; accumulators change only through swaps
//   MAC_RUN  | operands captured; lanes 0..3 commit at the end of beats 0..3
module systolic_mac_pe #(
  parameter int  BUS_W  = 4,
  parameter int  ELEM_W = 8,
  parameter bit  SIGNED = 1'b1,
  parameter bit  SAT    = 1'b0,
  localparam int WORD_W = 2 * ELEM_W,
  localparam int BEATS  = WORD_W / BUS_W,
  localparam int BEAT_W = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [BUS_W-1:0]  col_in,
  input  logic              col_ctrl_in,
  input  logic [BUS_W-1:0]  row_in,
  input  logic              row_ctrl_in,
  output logic [BUS_W-1:0]  col_out,
  output logic              col_ctrl_out,
  output logic [BUS_W-1:0]  row_out,
  output logic              row_ctrl_out,
  output logic [BEAT_W-1:0] beat,
  output logic              ovf
);

  typedef enum logic {MAC_IDLE, MAC_RUN} mac_state_t;

  localparam logic [1:0] OP_PASS = 2'd0;
  localparam logic [1:0] OP_MAC  = 2'd1;
  localparam logic [1:0] OP_SWL  = 2'd2;  // swap C00 (column) / C01 (row)
  localparam logic [1:0] OP_SWH  = 2'd3;  // swap C10 (column) / C11 (row)

  // Range limits of the exact sum, held two bits wider than the accumulator.
  localparam logic signed [WORD_W+1:0] HI_S = {3'b000, {(WORD_W-1){1'b1}}};
  localparam logic signed [WORD_W+1:0] LO_S = {3'b111, {(WORD_W-1){1'b0}}};
  localparam logic signed [WORD_W+1:0] HI_U = {2'b00, {WORD_W{1'b1}}};
  localparam logic signed [WORD_W+1:0] LO_U = '0;
  localparam logic signed [WORD_W+1:0] HI   = SIGNED ? HI_S : HI_U;
  localparam logic signed [WORD_W+1:0] LO   = SIGNED ? LO_S : LO_U;

  mac_state_t mac_state, mac_state_nxt;

  logic                     boundary;
  logic [WORD_W-BUS_W-1:0]  col_sh, row_sh;
  logic [BEATS-2:0]         col_csh, row_csh;
  logic [WORD_W-1:0]        col_word, row_word;
  logic [BEATS-1:0]         col_cword, row_cword;
  logic [1:0]               col_op, row_op;
  logic                     col_clr;
  logic                     mac_trig;

  logic [WORD_W-1:0]        col_obuf, row_obuf;
  logic [BEATS-1:0]         col_cobuf, row_cobuf;
  logic [WORD_W-1:0]        acc [4];
  logic [WORD_W-1:0]        acc_fwd [4];

  logic [ELEM_W-1:0]        opa0, opa1, opb0, opb1;
  logic                     op_clr;

  logic                     lane_ok;
  logic [1:0]               lane;
  logic                     commit_en;
  logic [ELEM_W-1:0]        mul_a, mul_b;
  logic signed [WORD_W+1:0] mul_a_x, mul_b_x, prod_x, acc_x, sum_x;
  logic [WORD_W-1:0]        acc_cur;
  logic [WORD_W-1:0]        mac_res;
  logic                     over_hi, under_lo, mac_ovf;

  // Frame decode: the full word is the shifted buffer plus the live last nibble.
  assign boundary  = ena && (beat == BEAT_W'(BEATS - 1));
  assign col_word  = {col_sh, col_in};
  assign row_word  = {row_sh, row_in};
  assign col_cword = {col_csh, col_ctrl_in};
  assign row_cword = {row_csh, row_ctrl_in};
  assign col_op    = col_cword[BEATS-1 -: 2];
  assign row_op    = row_cword[BEATS-1 -: 2];
  assign col_clr   = col_cword[BEATS-3];
  assign mac_trig  = boundary && (col_op == OP_MAC) && (row_op == OP_MAC);

  // Only beats 0..3 carry a product lane; longer frames idle after beat 3.
  assign lane_ok   = (32'(beat) < 32'd4);
  assign lane      = beat[1:0];
  assign commit_en = (mac_state == MAC_RUN) && ena && lane_ok;

  // Lane product and exact sum, then wrap or clamp into the accumulator width.
  always_comb begin
    mul_a    = lane[1] ? opa1 : opa0;
    mul_b    = lane[0] ? opb1 : opb0;
    mul_a_x  = {{(WORD_W+2-ELEM_W){SIGNED & mul_a[ELEM_W-1]}}, mul_a};
    mul_b_x  = {{(WORD_W+2-ELEM_W){SIGNED & mul_b[ELEM_W-1]}}, mul_b};
    prod_x   = mul_a_x * mul_b_x;
    acc_cur  = acc[lane];
    acc_x    = {{2{SIGNED & acc_cur[WORD_W-1]}}, acc_cur};
    sum_x    = op_clr ? prod_x : (acc_x + prod_x);
    over_hi  = (sum_x > HI);
    under_lo = (sum_x < LO);
    mac_ovf  = over_hi | under_lo;
    mac_res  = sum_x[WORD_W-1:0];
    if (SAT && over_hi) begin
      mac_res = HI[WORD_W-1:0];
    end else if (SAT && under_lo) begin
      mac_res = LO[WORD_W-1:0];
    end
  end

  // Accumulator values as seen by a swap at the boundary, including a same-edge commit.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      acc_fwd[i] = (commit_en && (lane == 2'(i))) ? mac_res : acc[i];
    end
  end

  // Beat counter and input shift buffers.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat    <= '0;
      col_sh  <= '0;
      row_sh  <= '0;
      col_csh <= '0;
      row_csh <= '0;
    end else if (ena) begin
      beat <= (beat == BEAT_W'(BEATS - 1)) ? '0 : beat + 1'b1;
      if (!boundary) begin
        col_sh  <= {col_sh[WORD_W-2*BUS_W-1:0], col_in};
        row_sh  <= {row_sh[WORD_W-2*BUS_W-1:0], row_in};
        col_csh <= {col_csh[BEATS-3:0], col_ctrl_in};
        row_csh <= {row_csh[BEATS-3:0], row_ctrl_in};
      end
    end
  end

  // Output buffers: forward the incoming word, or the swapped-out accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_obuf  <= '0;
      row_obuf  <= '0;
      col_cobuf <= '0;
      row_cobuf <= '0;
    end else if (boundary) begin
      col_cobuf <= col_cword;
      row_cobuf <= row_cword;
      case (col_op)
        OP_SWL:  col_obuf <= acc_fwd[0];
        OP_SWH:  col_obuf <= acc_fwd[2];
        default: col_obuf <= col_word;
      endcase
      case (row_op)
        OP_SWL:  row_obuf <= acc_fwd[1];
        OP_SWH:  row_obuf <= acc_fwd[3];
        default: row_obuf <= row_word;
      endcase
    end
  end

  // Accumulator tile: lane commits first, a boundary swap load overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        acc[i] <= '0;
      end
    end else begin
      if (commit_en) begin
        acc[lane] <= mac_res;
      end
      if (boundary) begin
        if (col_op == OP_SWL) acc[0] <= col_word;
        if (col_op == OP_SWH) acc[2] <= col_word;
        if (row_op == OP_SWL) acc[1] <= row_word;
        if (row_op == OP_SWH) acc[3] <= row_word;
      end
    end
  end

  // MAC operand capture at the triggering boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa0   <= '0;
      opa1   <= '0;
      opb0   <= '0;
      opb1   <= '0;
      op_clr <= 1'b0;
    end else if (mac_trig) begin
      opa0   <= col_word[WORD_W-1 -: ELEM_W];
      opa1   <= col_word[ELEM_W-1:0];
      opb0   <= row_word[WORD_W-1 -: ELEM_W];
      opb1   <= row_word[ELEM_W-1:0];
      op_clr <= col_clr;
    end
  end

  // Sticky overflow, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (commit_en && mac_ovf) begin
      ovf <= 1'b1;
    end
  end

  // MAC sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_state <= MAC_IDLE;
    end else begin
      mac_state <= mac_state_nxt;
    end
  end

  // MAC sequencer next state; a new trigger at the last lane re-arms directly.
  always_comb begin
    mac_state_nxt = mac_state;
    case (mac_state)
      MAC_IDLE: begin
        if (mac_trig) mac_state_nxt = MAC_RUN;
      end
      MAC_RUN: begin
        if (mac_trig) begin
          mac_state_nxt = MAC_RUN;
        end else if (commit_en && (lane == 2'd3)) begin
          mac_state_nxt = MAC_IDLE;
        end
      end
      default: mac_state_nxt = MAC_IDLE;
    endcase
  end

  // Outputs are a register mux indexed by the beat counter.
  assign col_out      = col_obuf[(BEATS - 1 - int'(beat)) * BUS_W +: BUS_W];
  assign row_out      = row_obuf[(BEATS - 1 - int'(beat)) * BUS_W +: BUS_W];
  assign col_ctrl_out = col_cobuf[BEATS - 1 - int'(beat)];
  assign row_ctrl_out = row_cobuf[BEATS - 1 - int'(beat)];

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Bench for systolic_mac_pe: three instances (signed wrap, signed saturate,
// unsigned saturate) share one stimulus stream and are checked every beat
// against a frame-level arithmetic model of the tile.
module tb_systolic_mac_pe;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst, ena;
  logic [3:0] col_in, row_in;
  logic col_ctrl_in, row_ctrl_in;
  logic [NI-1:0][3:0] col_out_v, row_out_v;
  logic [NI-1:0] col_ctrl_out_v, row_ctrl_out_v, ovf_v;
  logic [NI-1:0][1:0] beat_v;

  int nvec = 0;
  int nerr = 0;

  // model state
  logic [15:0] m_acc [NI][4];
  logic [15:0] m_cout [NI];
  logic [15:0] m_rout [NI];
  logic [3:0]  m_cco, m_rco;
  logic        m_ovf [NI];
  bit          m_pend;
  logic [7:0]  m_a0, m_a1, m_b0, m_b1;
  bit          m_clr;

  always #5 clk = ~clk;

  systolic_mac_pe #(.BUS_W(4), .ELEM_W(8), .SIGNED(1'b1), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .ena(ena),
    .col_in(col_in), .col_ctrl_in(col_ctrl_in), .row_in(row_in), .row_ctrl_in(row_ctrl_in),
    .col_out(col_out_v[0]), .col_ctrl_out(col_ctrl_out_v[0]),
    .row_out(row_out_v[0]), .row_ctrl_out(row_ctrl_out_v[0]),
    .beat(beat_v[0]), .ovf(ovf_v[0]));

  systolic_mac_pe #(.BUS_W(4), .ELEM_W(8), .SIGNED(1'b1), .SAT(1'b1)) u_ssat (
    .clk(clk), .rst(rst), .ena(ena),
    .col_in(col_in), .col_ctrl_in(col_ctrl_in), .row_in(row_in), .row_ctrl_in(row_ctrl_in),
    .col_out(col_out_v[1]), .col_ctrl_out(col_ctrl_out_v[1]),
    .row_out(row_out_v[1]), .row_ctrl_out(row_ctrl_out_v[1]),
    .beat(beat_v[1]), .ovf(ovf_v[1]));

  systolic_mac_pe #(.BUS_W(4), .ELEM_W(8), .SIGNED(1'b0), .SAT(1'b1)) u_usat (
    .clk(clk), .rst(rst), .ena(ena),
    .col_in(col_in), .col_ctrl_in(col_ctrl_in), .row_in(row_in), .row_ctrl_in(row_ctrl_in),
    .col_out(col_out_v[2]), .col_ctrl_out(col_ctrl_out_v[2]),
    .row_out(row_out_v[2]), .row_ctrl_out(row_ctrl_out_v[2]),
    .beat(beat_v[2]), .ovf(ovf_v[2]));

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, i, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 4; k++) m_acc[i][k] = '0;
      m_cout[i] = '0;
      m_rout[i] = '0;
      m_ovf[i]  = 1'b0;
    end
    m_cco = '0; m_rco = '0; m_pend = 0; m_clr = 0;
    m_a0 = '0; m_a1 = '0; m_b0 = '0; m_b1 = '0;
  endtask

  // One accumulate/clear step in exact integer arithmetic.
  task automatic m_commit(input int i, input int k, input logic [7:0] a, input logic [7:0] b, input bit clr);
    bit sgn, sat;
    longint av, bv, accv, sum, lo, hi;
    sgn  = (i < 2);
    sat  = (i >= 1);
    av   = sgn ? longint'($signed(a)) : longint'(a);
    bv   = sgn ? longint'($signed(b)) : longint'(b);
    accv = sgn ? longint'($signed(m_acc[i][k])) : longint'(m_acc[i][k]);
    sum  = clr ? av * bv : accv + av * bv;
    lo   = sgn ? -32768 : 0;
    hi   = sgn ? 32767 : 65535;
    if (sum < lo || sum > hi) begin
      m_ovf[i] = 1'b1;
      if (sat) sum = (sum < lo) ? lo : hi;
    end
    m_acc[i][k] = 16'(sum);
  endtask

  // Effect of one complete frame: pending products land during the frame,
  // then the boundary forwards/swaps and may arm a new MAC.
  task automatic model_frame(input logic [15:0] cw, input logic [3:0] cc, input logic [15:0] rw, input logic [3:0] rc);
    for (int i = 0; i < NI; i++) begin
      if (m_pend) begin
        m_commit(i, 0, m_a0, m_b0, m_clr);
        m_commit(i, 1, m_a0, m_b1, m_clr);
        m_commit(i, 2, m_a1, m_b0, m_clr);
        m_commit(i, 3, m_a1, m_b1, m_clr);
      end
      case (cc[3:2])
        2'd2: begin m_cout[i] = m_acc[i][0]; m_acc[i][0] = cw; end
        2'd3: begin m_cout[i] = m_acc[i][2]; m_acc[i][2] = cw; end
        default: m_cout[i] = cw;
      endcase
      case (rc[3:2])
        2'd2: begin m_rout[i] = m_acc[i][1]; m_acc[i][1] = rw; end
        2'd3: begin m_rout[i] = m_acc[i][3]; m_acc[i][3] = rw; end
        default: m_rout[i] = rw;
      endcase
    end
    m_cco  = cc;
    m_rco  = rc;
    m_pend = (cc[3:2] == 2'd1) && (rc[3:2] == 2'd1);
    if (m_pend) begin
      m_a0 = cw[15:8]; m_a1 = cw[7:0];
      m_b0 = rw[15:8]; m_b1 = rw[7:0];
      m_clr = cc[1];
    end
  endtask

  task automatic check_beat(input int b);
    for (int i = 0; i < NI; i++) begin
      chk("beat", i, 32'(beat_v[i]), 32'(b));
      chk("col_out", i, 32'(col_out_v[i]), 32'(m_cout[i][(3-b)*4 +: 4]));
      chk("row_out", i, 32'(row_out_v[i]), 32'(m_rout[i][(3-b)*4 +: 4]));
      chk("col_ctrl_out", i, 32'(col_ctrl_out_v[i]), 32'(m_cco[3-b]));
      chk("row_ctrl_out", i, 32'(row_ctrl_out_v[i]), 32'(m_rco[3-b]));
      if (b == 0) chk("ovf", i, 32'(ovf_v[i]), 32'(m_ovf[i]));
    end
  endtask

  task automatic drive(input logic [15:0] cw, input logic [3:0] cc, input logic [15:0] rw, input logic [3:0] rc, input int b);
    col_in      = cw[(3-b)*4 +: 4];
    row_in      = rw[(3-b)*4 +: 4];
    col_ctrl_in = cc[3-b];
    row_ctrl_in = rc[3-b];
  endtask

  // Called at a negedge at beat 0; returns at the negedge starting the next frame.
  task automatic run_frame(input logic [15:0] cw, input logic [3:0] cc, input logic [15:0] rw, input logic [3:0] rc,
                           input int hold_at, input int hold_len, input int rst_at);
    for (int b = 0; b < 4; b++) begin
      check_beat(b);
      if (b == rst_at) begin
        rst = 1'b1;
        drive(cw, cc, rw, rc, b);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        return;
      end
      if (b == hold_at) begin
        ena = 1'b0;
        for (int k = 0; k < hold_len; k++) begin
          col_in = 4'($urandom); row_in = 4'($urandom);
          col_ctrl_in = 1'($urandom); row_ctrl_in = 1'($urandom);
          @(negedge clk);
          check_beat(b);
        end
        ena = 1'b1;
      end
      drive(cw, cc, rw, rc, b);
      @(negedge clk);
    end
    model_frame(cw, cc, rw, rc);
  endtask

  task automatic rf(input logic [15:0] cw, input logic [3:0] cc, input logic [15:0] rw, input logic [3:0] rc);
    run_frame(cw, cc, rw, rc, -1, 0, -1);
  endtask

  initial begin
    logic [15:0] cw, rw;
    logic [3:0]  cc, rc;
    int hold_at, hold_len;

    model_reset();
    rst = 1'b1; ena = 1'b1;
    col_in = 4'($urandom); row_in = 4'($urandom);
    col_ctrl_in = 1'b1; row_ctrl_in = 1'b1;
    @(negedge clk);
    col_in = 4'($urandom); row_in = 4'($urandom);
    @(negedge clk);
    check_beat(0);
    rst = 1'b0;

    // pass-through
    rf(16'h1234, 4'b0000, 16'h00FF, 4'b0000);
    rf(16'h0000, 4'b0000, 16'h0000, 4'b0000);
    // swap C00 in and out
    rf(16'h0005, 4'b1000, 16'h0000, 4'b0000);
    rf(16'h0000, 4'b1000, 16'h0000, 4'b0000);
    rf(16'h0000, 4'b0000, 16'h0000, 4'b0000);
    // MAC with clear, read back all four accumulators
    rf(16'h03FE, 4'b0110, 16'h0405, 4'b0100);
    rf(16'h0000, 4'b0000, 16'h0000, 4'b0000);
    rf(16'h0000, 4'b1000, 16'h0000, 4'b1000);
    rf(16'h0000, 4'b1100, 16'h0000, 4'b1100);
    rf(16'h0000, 4'b0000, 16'h0000, 4'b0000);
    // C11 commit colliding with a row swap of C11
    rf(16'h0203, 4'b0100, 16'h0405, 4'b0100);
    rf(16'h1111, 4'b1000, 16'h2222, 4'b1100);
    rf(16'h0000, 4'b0000, 16'h0000, 4'b1100);
    rf(16'h0000, 4'b0000, 16'h0000, 4'b0000);
    // saturation / wrap near the positive limit
    rf(16'h7FF0, 4'b1000, 16'h0000, 4'b0000);
    rf(16'h7F00, 4'b0100, 16'h7F00, 4'b0100);
    rf(16'h0000, 4'b0000, 16'h0000, 4'b0000);
    rf(16'h0000, 4'b1000, 16'h0000, 4'b0000);
    rf(16'h0000, 4'b0000, 16'h0000, 4'b0000);
    // enable hold for 3 clocks at beat 1
    run_frame(16'hA5C3, 4'b0000, 16'h5A3C, 4'b0000, 1, 3, -1);
    rf(16'h0000, 4'b0000, 16'h0000, 4'b0000);
    // reset mid-frame while a MAC is pending
    rf(16'h0102, 4'b0100, 16'h0304, 4'b0100);
    run_frame(16'hFFFF, 4'b1000, 16'hFFFF, 4'b1000, -1, 0, 2);
    rf(16'h0000, 4'b1000, 16'h0000, 4'b1000);
    rf(16'h0000, 4'b1100, 16'h0000, 4'b1100);
    rf(16'h0000, 4'b0000, 16'h0000, 4'b0000);

    // random frames, biased toward MACs, with occasional holds
    for (int f = 0; f < 80; f++) begin
      cw = 16'($urandom); rw = 16'($urandom);
      cc = 4'($urandom);  rc = 4'($urandom);
      if ($urandom_range(0, 9) < 4) begin
        cc[3:2] = 2'd1;
        rc[3:2] = 2'd1;
      end
      hold_at  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      hold_len = int'($urandom_range(1, 2));
      run_frame(cw, cc, rw, rc, hold_at, hold_len, -1);
    end
    rf(16'h0000, 4'b0000, 16'h0000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
